// File: rtl/apb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_regfile_pkg
// Purpose  : Shared types and constants for the watermark APB register file.
// Revision : 1.0 - initial release
// ============================================================================
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_MEMWAIT = 2'd3
    } apb_state_e;

    localparam int c_ctrl_start = 0;
    localparam int c_ctrl_busy  = 1;
    localparam int c_ctrl_done  = 2;

    localparam int c_reg_ctrl  = 0;
    localparam int c_reg_white = 1;
    localparam int c_reg_psize = 2;
    localparam int c_reg_wsize = 3;
    localparam int c_reg_bsize = 4;
    localparam int c_reg_edge  = 5;
    localparam int c_reg_amin  = 6;
    localparam int c_reg_amax  = 7;
    localparam int c_reg_bmin  = 8;
    localparam int c_reg_bmax  = 9;

endpackage
`default_nettype wire

// File: rtl/sp_ram_sync.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_sync
// Purpose  : Single-port synchronous RAM, one-cycle read latency, no reset.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_sync #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_q;

    // Read data holds between reads so it survives an idle cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                r_rdata_q <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/apb_image_regfile.sv
`default_nettype none
// ============================================================================
// Module   : apb_image_regfile
// Purpose  : APB3 register file + pixel memory for the watermark engine.
// Revision : 1.0 - initial release
// ============================================================================
module apb_image_regfile
    import apb_regfile_pkg::*;
#(
    parameter int AMBA_WORD       = 16,
    parameter int AMBA_ADDR_DEPTH = 20,
    parameter int NUM_CFG         = 10,
    parameter int MEM_DEPTH       = 1024,
    parameter int WHITE_RST       = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            psel,
    input  logic                            penable,
    input  logic                            pwrite,
    input  logic [AMBA_ADDR_DEPTH-1:0]      paddr,
    input  logic [AMBA_WORD-1:0]            pwdata,
    output logic [AMBA_WORD-1:0]            prdata,
    output logic                            pready,
    output logic                            pslverr,
    output logic                            start,
    output logic                            busy,
    input  logic                            core_done,
    output logic [NUM_CFG*AMBA_WORD-1:0]    cfg_flat,
    input  logic                            core_rd_en,
    input  logic [$clog2(MEM_DEPTH)-1:0]    core_rd_addr,
    output logic [AMBA_WORD-1:0]            core_rd_data,
    output logic                            core_rd_valid
);

    localparam int c_mem_aw = $clog2(MEM_DEPTH);
    localparam int c_cfg_aw = $clog2(NUM_CFG);
    localparam logic [AMBA_ADDR_DEPTH-1:0] c_mem_base = AMBA_ADDR_DEPTH'(NUM_CFG);
    localparam logic [AMBA_ADDR_DEPTH-1:0] c_mem_end  = AMBA_ADDR_DEPTH'(NUM_CFG + MEM_DEPTH);

    apb_state_e r_state_q, w_state_d;
    logic r_issued_q, w_issued_d;
    logic r_busy_q, w_busy_d;
    logic r_done_q, w_done_d;
    logic r_start_q, w_start_d;
    logic r_core_valid_q, w_core_valid_d;
    logic r_core_oob_q, w_core_oob_d;
    logic [AMBA_WORD-1:0] r_cfg_q [1:NUM_CFG-1];
    logic [AMBA_WORD-1:0] w_cfg_d [1:NUM_CFG-1];

    logic                 w_in_cfg, w_in_mem, w_busy_block, w_err;
    logic [c_cfg_aw-1:0]  w_cfg_idx;
    logic [c_mem_aw-1:0]  w_mem_idx;
    logic [AMBA_WORD-1:0] w_ctrl_word, w_cfg_rdata;
    logic                 w_core_in_range;
    logic                 w_apb_rd_issue, w_apb_wr, w_start_set, w_done_clr;
    logic                 w_ram_en, w_ram_we;
    logic [c_mem_aw-1:0]  w_ram_addr;
    logic [AMBA_WORD-1:0] w_ram_rdata;

    // ---------------- address decode ----------------
    assign w_in_cfg  = (paddr < c_mem_base);
    assign w_in_mem  = !w_in_cfg && (paddr < c_mem_end);
    assign w_cfg_idx = c_cfg_aw'(paddr);
    assign w_mem_idx = c_mem_aw'(paddr - c_mem_base);

    // Writes that would disturb a running core are refused while busy.
    assign w_busy_block = r_busy_q && pwrite &&
                          ((w_in_cfg && (w_cfg_idx == '0) && pwdata[c_ctrl_start]) ||
                           (w_in_cfg && (w_cfg_idx != '0)) ||
                           w_in_mem);
    assign w_err = !(w_in_cfg || w_in_mem) || w_busy_block;

    always_comb begin
        w_ctrl_word              = '0;
        w_ctrl_word[c_ctrl_busy] = r_busy_q;
        w_ctrl_word[c_ctrl_done] = r_done_q;
    end

    assign w_cfg_rdata = (w_cfg_idx == '0) ? w_ctrl_word : r_cfg_q[w_cfg_idx];

    // ---------------- APB FSM ----------------
    always_comb begin
        w_state_d      = r_state_q;
        w_issued_d     = r_issued_q;
        w_cfg_d        = r_cfg_q;
        pready         = 1'b0;
        pslverr        = 1'b0;
        prdata         = '0;
        w_apb_rd_issue = 1'b0;
        w_apb_wr       = 1'b0;
        w_start_set    = 1'b0;
        w_done_clr     = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (psel && !penable) w_state_d = ST_SETUP;
            end
            ST_SETUP: begin
                w_issued_d = 1'b0;
                w_state_d  = psel ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                if (w_err) begin
                    pready  = 1'b1;
                    pslverr = 1'b1;
                end else if (w_in_cfg) begin
                    pready = 1'b1;
                    if (!pwrite) begin
                        prdata = w_cfg_rdata;
                    end else if (w_cfg_idx == '0) begin
                        w_start_set = pwdata[c_ctrl_start];
                        w_done_clr  = pwdata[c_ctrl_done];
                    end else begin
                        w_cfg_d[w_cfg_idx] = pwdata;
                    end
                end else if (pwrite) begin
                    // Core owns the RAM port this cycle; retry the write next cycle.
                    if (!core_rd_en) begin
                        w_apb_wr = 1'b1;
                        pready   = 1'b1;
                    end
                end else begin
                    if (!core_rd_en) begin
                        w_apb_rd_issue = 1'b1;
                        w_issued_d     = 1'b1;
                    end
                    w_state_d = ST_MEMWAIT;
                end
                if (pready) w_state_d = psel ? ST_SETUP : ST_IDLE;
            end
            ST_MEMWAIT: begin
                if (r_issued_q) begin
                    pready    = 1'b1;
                    prdata    = w_ram_rdata;
                    w_state_d = psel ? ST_SETUP : ST_IDLE;
                end else if (!core_rd_en) begin
                    w_apb_rd_issue = 1'b1;
                    w_issued_d     = 1'b1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // ---------------- status handshake ----------------
    always_comb begin
        w_start_d = w_start_set;
        w_busy_d  = w_start_set ? 1'b1 : (core_done ? 1'b0 : r_busy_q);
        w_done_d  = core_done ? 1'b1 : (w_done_clr ? 1'b0 : r_done_q);
    end

    // ---------------- RAM port arbitration ----------------
    assign w_core_in_range = (32'(core_rd_addr) < MEM_DEPTH);
    assign w_core_valid_d  = core_rd_en;
    assign w_core_oob_d    = !w_core_in_range;
    assign w_ram_en        = (core_rd_en && w_core_in_range) || w_apb_rd_issue || w_apb_wr;
    assign w_ram_we        = w_apb_wr;
    assign w_ram_addr      = core_rd_en ? core_rd_addr : w_mem_idx;

    sp_ram_sync #(
        .WIDTH (AMBA_WORD),
        .DEPTH (MEM_DEPTH),
        .AW    (c_mem_aw)
    ) u_ram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (pwdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= ST_IDLE;
            r_issued_q     <= 1'b0;
            r_busy_q       <= 1'b0;
            r_done_q       <= 1'b0;
            r_start_q      <= 1'b0;
            r_core_valid_q <= 1'b0;
            r_core_oob_q   <= 1'b0;
            for (int i = 1; i < NUM_CFG; i++) begin
                r_cfg_q[i] <= (i == c_reg_white) ? AMBA_WORD'(WHITE_RST) : '0;
            end
        end else begin
            r_state_q      <= w_state_d;
            r_issued_q     <= w_issued_d;
            r_busy_q       <= w_busy_d;
            r_done_q       <= w_done_d;
            r_start_q      <= w_start_d;
            r_core_valid_q <= w_core_valid_d;
            r_core_oob_q   <= w_core_oob_d;
            r_cfg_q        <= w_cfg_d;
        end
    end

    assign start         = r_start_q;
    assign busy          = r_busy_q;
    assign core_rd_valid = r_core_valid_q;
    assign core_rd_data  = (r_core_valid_q && !r_core_oob_q) ? w_ram_rdata : '0;

    assign cfg_flat[0 +: AMBA_WORD] = w_ctrl_word;
    for (genvar gi = 1; gi < NUM_CFG; gi++) begin : g_cfg_flat
        assign cfg_flat[gi*AMBA_WORD +: AMBA_WORD] = r_cfg_q[gi];
    end

endmodule
`default_nettype wire

// File: doc/apb_image_regfile.md
Name: apb_image_regfile

Overview:
- Parametrised APB3 slave register file for the watermarking engine; successor to the flat register bank.
- Holds the configuration registers (CTRL, WhitePixel, sizes, thresholds, A/B factors) and the image pixel memory. The memory holds primary pixels followed by watermark pixels.
- Adds a full PSEL/PENABLE/PREADY handshake, PSLVERR, a CTRL/status handshake with the core (start pulse, busy, sticky done), and a second read port for the watermark core with arbitration.

Parameters:
- AMBA_WORD, 16: data width of every register and pixel.
- AMBA_ADDR_DEPTH, 20: APB address width.
- NUM_CFG, 10: configuration registers at addresses 0..NUM_CFG-1.
- MEM_DEPTH, 1024: pixel words at addresses NUM_CFG..NUM_CFG+MEM_DEPTH-1.
- WHITE_RST, 255: reset value of WhitePixel (address 1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  AMBA_ADDR_DEPTH  APB word address.
- pwdata  in  AMBA_WORD  write data.
- prdata  out  AMBA_WORD  read data, valid when pready=1.
- pready  out  1  transfer complete.
- pslverr  out  1  error, valid with pready.
- start  out  1  one-cycle pulse to the core.
- busy  out  1  core running.
- core_done  in  1  one-cycle pulse from the core.
- cfg_flat  out  NUM_CFG*AMBA_WORD  all configuration registers, register i at bits [i*AMBA_WORD +: AMBA_WORD].
- core_rd_en  in  1  core memory read request.
- core_rd_addr  in  clog2(MEM_DEPTH)  pixel index, 0-based.
- core_rd_data  out  AMBA_WORD  read data.
- core_rd_valid  out  1  core_rd_data valid.

Behaviour:
- Reset values:
  - All config registers 0, except WhitePixel = WHITE_RST.
  - prdata=0, pready=0, pslverr=0, start=0, busy=0, done=0, core_rd_valid=0, core_rd_data=0.
  - Memory contents are not reset.
  - Reset mid-transfer aborts the transfer, returns the FSM to IDLE and clears busy/done.
- APB FSM states: IDLE, SETUP, ACCESS, MEMWAIT.
  - IDLE -> SETUP on psel & !penable.
  - SETUP -> ACCESS.
  - ACCESS completes in the same cycle (pready=1) for config, error and memory-write accesses.
  - A memory read goes to MEMWAIT. pready rises the cycle after the RAM read is actually issued.
  - After pready, the FSM returns to IDLE, or to SETUP if psel stays asserted.
  - pready is combinational from state, so it is high only in the completing cycle.
- Address decode:
  - paddr < NUM_CFG: config register.
  - paddr < NUM_CFG+MEM_DEPTH: memory, index = paddr - NUM_CFG.
  - Otherwise: error with pslverr=1, prdata=0 and no side effect.
- CTRL (address 0):
  - bit0 START: write-1 produces one start pulse the following cycle and sets busy. Reads return 0.
  - bit1 BUSY: read-only.
  - bit2 DONE: sticky, set by core_done. Write-1 clears it.
  - Other bits read as 0.
- busy:
  - Set with start, cleared on core_done.
  - core_done while not busy: done is still set, busy stays 0.
  - core_done and a DONE-clear write in the same cycle: set wins.
- While busy, these accesses return pslverr=1 and are ignored:
  - writing START=1;
  - any write to config addresses 1..NUM_CFG-1;
  - any memory write.
  - Reads are always allowed.
- Memory:
  - Single-port synchronous RAM with a one-cycle read latency.
  - The core port has priority. Any cycle with core_rd_en=1 blocks the APB read issue and extends MEMWAIT, with no bound.
  - Core read: core_rd_valid=1 exactly one cycle after core_rd_en, with data from core_rd_addr.
  - core_rd_addr >= MEM_DEPTH returns 0.
  - A core read and an APB memory write in the same cycle: the write is delayed a cycle, pready stays 0 that cycle.
- cfg_flat is a registered copy, updated the cycle after the write.

Decomposition:
- Shared package apb_regfile_pkg holds:
  - APB FSM state enum;
  - CTRL bit positions (START=0, BUSY=1, DONE=2);
  - config register indices: CTRL=0, WHITE=1, PSIZE=2, WSIZE=3, BSIZE=4, EDGE=5, AMIN=6, AMAX=7, BMIN=8, BMAX=9.
- One sub-module, sp_ram_sync (parametrised width/depth, one-cycle read), so synthesis maps it to block RAM.

Test Plan:
- Reset then APB reads of addresses 0 and 1 -> prdata 0x0000 and 0x00FF, pslverr=0, pready in the ACCESS cycle.
- APB write 0x1234 to address 10 (pixel 0), then read address 10 -> 0x1234 with pready exactly one cycle after ACCESS (MEMWAIT); cfg_flat is unchanged.
- Write CTRL=0x1 -> start high exactly 1 cycle and busy=1.
  - While busy, write address 2 -> pslverr=1 and the value is unchanged.
  - Pulse core_done -> busy=0 and a CTRL read returns 0x4.
  - Write CTRL=0x4 -> a CTRL read returns 0x0.
- Hold core_rd_en=1 for 3 cycles during an APB memory read -> pready is delayed 3 cycles, then returns the correct data. core_rd_valid follows each request by 1 cycle.
- APB access to address NUM_CFG+MEM_DEPTH (1034) -> pslverr=1, prdata=0, and no memory or config change.
- Assert rst during MEMWAIT -> pready=0 immediately, busy=0, the FSM is in IDLE, and the next transfer completes normally.
